rotating_xbar_sched: RTL and testbench
======================================

ROTATING_XBAR_SCHED -- requirements
Module: rotating_xbar_sched

Interface
REQ-001 SHALL have parameter NUM_DATA, default 4, number of lanes; power of two, at least 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 4, bits per lane.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port arst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous flush and pointer reset.
REQ-006 SHALL have port step_i  input  log2(NUM_DATA)  pointer increment per accepted beat.
REQ-007 SHALL have port data_i  input  NUM_DATA x DATA_WIDTH  input lane vector.
REQ-008 SHALL have port data_valid_i  input  1  input beat valid.
REQ-009 SHALL have port data_ready_o  output  1  input beat may be accepted.
REQ-010 SHALL have port data_o  output  NUM_DATA x DATA_WIDTH  rotated lane vector, head of buffer.
REQ-011 SHALL have port select_o  output  log2(NUM_DATA)  rotation used for the data_o beat.
REQ-012 SHALL have port data_valid_o  output  1  data_o/select_o valid.
REQ-013 SHALL have port data_ready_i  input  1  downstream accepts the head beat.

Function
REQ-014 SHALL hold rotation pointer ptr, log2(NUM_DATA) bits; wrap-around by natural modulo-NUM_DATA overflow.
REQ-015 SHALL accept an input beat when data_valid_i and data_ready_o are high and clear_i is low.
REQ-016 SHALL, on accept, store rotated[j] = data_i[(ptr+j) mod NUM_DATA] for every lane j, together with select = ptr.
REQ-017 SHALL, on accept, update ptr to (ptr + step_i) mod NUM_DATA; step_i = 0 holds ptr.
REQ-018 SHALL buffer up to 2 beats in FIFO order; states EMPTY (0), ONE (1), FULL (2).
REQ-019 SHALL drive data_ready_o = 1 unless FULL; data_ready_o SHALL NOT depend combinationally on data_ready_i.
REQ-020 SHALL drive data_valid_o = 1 in ONE or FULL, with data_o/select_o taken from the oldest entry.
REQ-021 SHALL pop the head when data_valid_o and data_ready_i are high.
REQ-022 SHALL give latency 1: a beat accepted at edge N is visible on data_o after edge N.
REQ-023 SHALL treat simultaneous push and pop as occupancy-neutral in ONE; in FULL, only a pop occurs.
REQ-024 SHALL keep data_o, select_o and data_valid_o stable while data_valid_o is high and data_ready_i is low.
REQ-025 SHALL, on clear_i high, empty the buffer, set ptr to 0 and ignore any push or pop that cycle.
REQ-026 SHALL make data_o a don't-care when EMPTY; select_o SHALL read 0 when EMPTY.

Reset
REQ-027 SHALL, while arst_ni is low, asynchronously force ptr=0, occupancy=EMPTY, data_valid_o=0, select_o=0 and data_ready_o=1.
REQ-028 SHALL, on reset asserted mid-operation, discard all buffered beats; no beat is delivered twice or partially.

Structure
REQ-029 SHALL place the lane/select typedefs and the FIFO depth constant (2) in a shared package rotating_xbar_pkg.
REQ-030 SHALL instantiate one sub-module rotating_xbar to compute the rotation from data_i and ptr; the buffer and pointer logic stays in this module.

Verification
REQ-031 SHALL check reset: arst_ni low, then released -> data_valid_o=0, data_ready_o=1, select_o=0.
REQ-032 SHALL check rotation: step_i=1, data_i lanes {3:0}=4'hD,C,B,A, 5 beats, data_ready_i=1 -> select_o=0,1,2,3,0; beat 2 gives data_o lane0=C, lane1=D, lane2=A, lane3=B.
REQ-033 SHALL check backpressure: data_ready_i=0, 3 valid beats offered -> 2 accepted, data_ready_o=0 at FULL, head stable; data_ready_i=1 -> beats drain in order.
REQ-034 SHALL check step wrap: step_i=3 from ptr=2 -> next select 1; step_i=0 -> select constant.
REQ-035 SHALL check clear: FULL with ptr=3, clear_i pulsed with data_valid_i=1 -> EMPTY, ptr=0, no accept that cycle, next beat select_o=0.
REQ-036 SHALL check random mode: random valid/ready/step over 10k cycles against a reference model -> zero mismatches and every select value 0..NUM_DATA-1 hit at least 100 times.

Source files
------------

// File: rtl/rotating_xbar_pkg.sv
// Shared types and constants for the rotating crossbar scheduler.
package rotating_xbar_pkg;

    // Default configuration of the scheduler
    localparam int unsigned DEF_NUM_DATA   = 4;
    localparam int unsigned DEF_DATA_WIDTH = 4;
    localparam int unsigned DEF_SEL_W      = $clog2(DEF_NUM_DATA);

    // Output buffer depth and occupancy encoding
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [OCC_W-1:0] ST_EMPTY = OCC_W'(0);
    localparam logic [OCC_W-1:0] ST_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0] ST_FULL  = OCC_W'(FIFO_DEPTH);

    // Lane, select and lane-vector types for the default configuration
    typedef logic [DEF_DATA_WIDTH-1:0]                    lane_t;
    typedef logic [DEF_SEL_W-1:0]                         sel_t;
    typedef logic [DEF_NUM_DATA-1:0][DEF_DATA_WIDTH-1:0]  lane_vec_t;

endpackage

// File: rtl/rotating_xbar.sv
// Combinational lane rotator: lane j of the output takes input lane (ptr + j) mod NUM_DATA.
module rotating_xbar
    import rotating_xbar_pkg::*;
#(
    parameter int unsigned  NUM_DATA   = DEF_NUM_DATA,
    parameter int unsigned  DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int unsigned SEL_W      = $clog2(NUM_DATA)
) (
    input  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]                    ptr_i,
    output logic [NUM_DATA-1:0][DATA_WIDTH-1:0] rotated_c_o
);

    // Index arithmetic wraps naturally because NUM_DATA is a power of two
    for (genvar j = 0; j < NUM_DATA; j++) begin : g_lane
        assign rotated_c_o[j] = data_i[SEL_W'(ptr_i + SEL_W'(j))];
    end

endmodule

// File: rtl/rotating_xbar_sched.sv
// Rotating crossbar scheduler: rotates each accepted beat by a running pointer
// and holds up to two rotated beats for a ready/valid downstream.
module rotating_xbar_sched
    import rotating_xbar_pkg::*;
#(
    parameter int unsigned  NUM_DATA   = DEF_NUM_DATA,
    parameter int unsigned  DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int unsigned SEL_W      = $clog2(NUM_DATA)
) (
    input  logic                                clk_i,
    input  logic                                arst_ni,
    input  logic                                clear_i,
    input  logic [SEL_W-1:0]                    step_i,
    input  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] data_i,
    input  logic                                data_valid_i,
    output logic                                data_ready_o,
    output logic [NUM_DATA-1:0][DATA_WIDTH-1:0] data_o,
    output logic [SEL_W-1:0]                    select_o,
    output logic                                data_valid_o,
    input  logic                                data_ready_i
);

    typedef logic [NUM_DATA-1:0][DATA_WIDTH-1:0] vec_t;

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    vec_t             head_q, head_d;
    logic [SEL_W-1:0] head_sel_q, head_sel_d;
    vec_t             tail_q, tail_d;
    logic [SEL_W-1:0] tail_sel_q, tail_sel_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;

    vec_t             rotated_c;
    logic             push_c;
    logic             pop_c;

    rotating_xbar #(
        .NUM_DATA   (NUM_DATA),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rotating_xbar (
        .data_i      (data_i),
        .ptr_i       (ptr_q),
        .rotated_c_o (rotated_c)
    );

    // State register: occupancy, pointer, two buffer slots and output flags
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            occ_q      <= ST_EMPTY;
            ptr_q      <= '0;
            head_q     <= '0;
            head_sel_q <= '0;
            tail_q     <= '0;
            tail_sel_q <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            occ_q      <= occ_d;
            ptr_q      <= ptr_d;
            head_q     <= head_d;
            head_sel_q <= head_sel_d;
            tail_q     <= tail_d;
            tail_sel_q <= tail_sel_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state: push/pop handshakes, FIFO shifting, pointer advance and flush
    always_comb begin
        occ_d      = occ_q;
        ptr_d      = ptr_q;
        head_d     = head_q;
        head_sel_d = head_sel_q;
        tail_d     = tail_q;
        tail_sel_d = tail_sel_q;
        push_c     = data_valid_i && ready_q && !clear_i;
        pop_c      = valid_q && data_ready_i && !clear_i;

        if (clear_i) begin
            occ_d      = ST_EMPTY;
            ptr_d      = '0;
            head_sel_d = '0;
        end else begin
            if (push_c) begin
                ptr_d = ptr_q + step_i;
            end
            case (occ_q)
                ST_EMPTY: begin
                    if (push_c) begin
                        head_d     = rotated_c;
                        head_sel_d = ptr_q;
                        occ_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push_c && pop_c) begin
                        head_d     = rotated_c;
                        head_sel_d = ptr_q;
                    end else if (push_c) begin
                        tail_d     = rotated_c;
                        tail_sel_d = ptr_q;
                        occ_d      = ST_FULL;
                    end else if (pop_c) begin
                        head_sel_d = '0;
                        occ_d      = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // No push is possible here: ready was low this cycle
                    if (pop_c) begin
                        head_d     = tail_q;
                        head_sel_d = tail_sel_q;
                        occ_d      = ST_ONE;
                    end
                end
                default: begin
                    occ_d      = ST_EMPTY;
                    head_sel_d = '0;
                end
            endcase
        end

        valid_d = (occ_d != ST_EMPTY);
        ready_d = (occ_d != ST_FULL);
    end

    assign data_o       = head_q;
    assign select_o     = head_sel_q;
    assign data_valid_o = valid_q;
    assign data_ready_o = ready_q;

endmodule

// File: tb/tb_rotating_xbar_sched.sv
// Self-checking bench for rotating_xbar_sched: queue-based reference model with
// a per-cycle compare process, plus directed vectors with literal expectations.
module tb_rotating_xbar_sched;
    import rotating_xbar_pkg::*;

    localparam int N  = DEF_NUM_DATA;
    localparam int W  = DEF_DATA_WIDTH;
    localparam int SW = DEF_SEL_W;

    typedef struct {
        lane_vec_t data;
        int        sel;
    } beat_t;

    logic      clk = 1'b0;
    logic      arst_ni = 1'b1;
    logic      clear_i = 1'b0;
    sel_t      step_i = '0;
    lane_vec_t data_i = '0;
    logic      data_valid_i = 1'b0;
    logic      data_ready_o;
    lane_vec_t data_o;
    sel_t      select_o;
    logic      data_valid_o;
    logic      data_ready_i = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    beat_t mq[$];
    int    m_ptr = 0;
    int    hits[N];

    rotating_xbar_sched #(
        .NUM_DATA   (N),
        .DATA_WIDTH (W)
    ) dut (
        .clk_i        (clk),
        .arst_ni      (arst_ni),
        .clear_i      (clear_i),
        .step_i       (step_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_o       (data_o),
        .select_o     (select_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: two-entry queue of rotated beats and an integer pointer
    initial begin
        forever begin
            @(posedge clk or negedge arst_ni);
            if (!arst_ni) begin
                mq.delete();
                m_ptr = 0;
            end else if (clear_i) begin
                mq.delete();
                m_ptr = 0;
            end else begin
                bit    do_pop;
                bit    do_push;
                beat_t e;
                do_pop  = (mq.size() > 0) && data_ready_i;
                do_push = data_valid_i && (mq.size() < 2);
                if (do_push) begin
                    for (int j = 0; j < N; j++) e.data[j] = data_i[(m_ptr + j) % N];
                    e.sel = m_ptr;
                    hits[m_ptr]++;
                    m_ptr = (m_ptr + int'(step_i)) % N;
                end
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(e);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                bit exp_valid;
                int exp_sel;
                exp_valid = (mq.size() > 0);
                exp_sel   = exp_valid ? mq[0].sel : 0;
                check("model_valid", 64'(data_valid_o), 64'(exp_valid));
                check("model_ready", 64'(data_ready_o), 64'(mq.size() < 2));
                check("model_select", 64'(select_o), 64'(exp_sel));
                if (exp_valid) check("model_data", 64'(data_o), 64'(mq[0].data));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle();
        arst_ni      = 1'b0;
        data_valid_i = 1'b0;
        data_ready_i = 1'b0;
        clear_i      = 1'b0;
        step_i       = '0;
        cycle();
        cycle();
        arst_ni = 1'b1;
        check("rst_valid", 64'(data_valid_o), 64'd0);
        check("rst_ready", 64'(data_ready_o), 64'd1);
        check("rst_select", 64'(select_o), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) hits[i] = 0;
        #2;
        arst_ni = 1'b0;
        cmp_en  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        arst_ni = 1'b1;
        check("rst_valid", 64'(data_valid_o), 64'd0);
        check("rst_ready", 64'(data_ready_o), 64'd1);
        check("rst_select", 64'(select_o), 64'd0);

        // Rotation: step 1, five beats, downstream always ready
        data_i       = 16'hDCBA;
        step_i       = 2'd1;
        data_valid_i = 1'b1;
        data_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("rot_select", 64'(select_o), 64'(k % 4));
            check("rot_valid", 64'(data_valid_o), 64'd1);
            if (k == 2) check("rot_data_beat2", 64'(data_o), 64'hBADC);
        end
        data_valid_i = 1'b0;
        cycle();
        check("rot_drained", 64'(data_valid_o), 64'd0);

        // Backpressure: three offers while stalled, two accepted
        do_reset();
        step_i       = 2'd1;
        data_ready_i = 1'b0;
        data_valid_i = 1'b1;
        data_i       = 16'h1234;
        cycle();
        check("bp_ready_one", 64'(data_ready_o), 64'd1);
        check("bp_head_data", 64'(data_o), 64'h1234);
        data_i = 16'h5678;
        cycle();
        check("bp_ready_full", 64'(data_ready_o), 64'd0);
        check("bp_head_stable", 64'(data_o), 64'h1234);
        data_i = 16'h9ABC;
        cycle();
        check("bp_ready_full2", 64'(data_ready_o), 64'd0);
        check("bp_head_stable2", 64'(data_o), 64'h1234);
        check("bp_sel_stable", 64'(select_o), 64'd0);
        data_valid_i = 1'b0;
        data_ready_i = 1'b1;
        cycle();
        check("bp_second_sel", 64'(select_o), 64'd1);
        check("bp_second_data", 64'(data_o), 64'h8567);
        check("bp_ready_back", 64'(data_ready_o), 64'd1);
        cycle();
        check("bp_empty", 64'(data_valid_o), 64'd0);
        check("bp_empty_sel", 64'(select_o), 64'd0);

        // Step wrap: 2 then 3 (2+3 wraps to 1), then 0 holds the pointer
        do_reset();
        data_ready_i = 1'b1;
        data_valid_i = 1'b1;
        data_i       = 16'h0F1E;
        step_i       = 2'd2;
        cycle();
        check("wrap_sel0", 64'(select_o), 64'd0);
        step_i = 2'd3;
        cycle();
        check("wrap_sel2", 64'(select_o), 64'd2);
        step_i = 2'd0;
        cycle();
        check("wrap_sel1", 64'(select_o), 64'd1);
        cycle();
        check("hold_sel1a", 64'(select_o), 64'd1);
        cycle();
        check("hold_sel1b", 64'(select_o), 64'd1);
        data_valid_i = 1'b0;
        cycle();

        // Clear while FULL with pointer 3 and valid input held high
        do_reset();
        data_ready_i = 1'b0;
        data_valid_i = 1'b1;
        data_i       = 16'h4321;
        step_i       = 2'd1;
        cycle();
        step_i = 2'd2;
        cycle();
        check("clr_full", 64'(data_ready_o), 64'd0);
        check("clr_head_sel", 64'(select_o), 64'd0);
        clear_i = 1'b1;
        cycle();
        check("clr_valid", 64'(data_valid_o), 64'd0);
        check("clr_ready", 64'(data_ready_o), 64'd1);
        check("clr_select", 64'(select_o), 64'd0);
        clear_i = 1'b0;
        cycle();
        check("clr_next_valid", 64'(data_valid_o), 64'd1);
        check("clr_next_sel", 64'(select_o), 64'd0);
        data_valid_i = 1'b0;
        data_ready_i = 1'b1;
        cycle();

        // Random traffic with occasional clear and one mid-run async reset
        for (int i = 0; i < N; i++) hits[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            cycle();
            data_valid_i = ($urandom_range(0, 99) < 70);
            data_ready_i = ($urandom_range(0, 99) < 60);
            step_i       = sel_t'($urandom_range(0, N - 1));
            data_i       = lane_vec_t'($urandom);
            clear_i      = ($urandom_range(0, 199) == 0);
            if (c == 5000) arst_ni = 1'b0;
            if (c == 5002) arst_ni = 1'b1;
        end
        data_valid_i = 1'b0;
        clear_i      = 1'b0;
        cycle();
        cycle();
        for (int s = 0; s < N; s++) begin
            check($sformatf("hits_sel%0d_ge100", s), 64'(hits[s] >= 100), 64'd1);
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
